// File: rtl/enc_parity_engine_pkg.sv
// Shared GF(2^8) arithmetic, RS(255,239) generator polynomial and FSM state type
// for the Reed-Solomon parity engine.
package enc_parity_engine_pkg;

   localparam int GF_M    = 8;
   localparam int GEN_LEN = 16;

   localparam logic [GF_M:0] EGF_PRI_POL = 9'h11D;

   typedef enum logic [1:0] {
      IDLE,
      ABSORB,
      DRAIN
   } state_t;

   typedef logic [GEN_LEN-1:0][GF_M-1:0] genPoly_t;

   // Shift-and-add multiply, reducing by the primitive polynomial whenever the top bit falls off.
   function automatic logic [GF_M-1:0] egf_mul(input logic [GF_M-1:0] a, input logic [GF_M-1:0] b);
      logic [GF_M-1:0] acc;
      logic [GF_M-1:0] shifted;
      acc     = '0;
      shifted = a;
      for (int i = 0; i < GF_M; i++) begin
         if (b[i]) begin
            acc = acc ^ shifted;
         end
         shifted = shifted[GF_M-1] ? ((shifted << 1) ^ EGF_PRI_POL[GF_M-1:0]) : (shifted << 1);
      end
      return acc;
   endfunction

   // g(x) = prod_{i=0}^{15} (x + alpha^i); the monic x^16 term is implicit and not stored.
   function automatic genPoly_t buildGenPoly();
      logic [GEN_LEN:0][GF_M-1:0] coef;
      logic [GF_M-1:0]            root;
      genPoly_t                   g;
      coef    = '0;
      coef[0] = GF_M'(1);
      root    = GF_M'(1);
      for (int i = 0; i < GEN_LEN; i++) begin
         for (int j = GEN_LEN; j >= 1; j--) begin
            coef[j] = coef[j-1] ^ egf_mul(coef[j], root);
         end
         coef[0] = egf_mul(coef[0], root);
         root    = egf_mul(root, GF_M'(2));
      end
      for (int k = 0; k < GEN_LEN; k++) begin
         g[k] = coef[k];
      end
      return g;
   endfunction

   localparam genPoly_t RS_GEN_POL = buildGenPoly();

endpackage

// File: rtl/enc_lfsr_step.sv
// One symbol of RS parity division: a combinational LFSR update that passes the
// parity through untouched when the stage is bypassed.
module enc_lfsr_step
   import enc_parity_engine_pkg::*;
#(
   parameter int EGF_ORDER = GF_M,
   parameter int PAR_LEN   = GEN_LEN
) (
   input  logic [PAR_LEN-1:0][EGF_ORDER-1:0] parPrev,
   input  logic [EGF_ORDER-1:0]              sym,
   input  logic                              enable,
   output logic [PAR_LEN-1:0][EGF_ORDER-1:0] parNext
);

   logic [EGF_ORDER-1:0] feedback;

   // The feedback symbol multiplies every generator tap; the register also shifts up by one symbol.
   always_comb begin
      feedback = sym ^ parPrev[PAR_LEN-1];
      parNext  = parPrev;
      if (enable) begin
         parNext[0] = egf_mul(feedback, RS_GEN_POL[0]);
         for (int j = 1; j < PAR_LEN; j++) begin
            parNext[j] = parPrev[j-1] ^ egf_mul(feedback, RS_GEN_POL[j]);
         end
      end
   end

endmodule

// File: rtl/enc_parity_engine.sv
// Streaming RS parity generator: absorbs up to SYM_NUM message symbols per beat,
// then drains the parity register SYM_NUM symbols at a time, highest degree first.
module enc_parity_engine
   import enc_parity_engine_pkg::*;
#(
   parameter int EGF_ORDER = GF_M,
   parameter int SYM_NUM   = 4,
   parameter int PAR_LEN   = GEN_LEN
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [SYM_NUM-1:0][EGF_ORDER-1:0]    in_data,
   input  logic [$clog2(SYM_NUM+1)-1:0]         in_cnt,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [SYM_NUM-1:0][EGF_ORDER-1:0]    out_data,
   output logic                                 out_last,
   output logic                                 busy
);

   localparam int CNT_W    = $clog2(SYM_NUM+1);
   localparam int BEATS    = (PAR_LEN + SYM_NUM - 1) / SYM_NUM;
   localparam int DRAIN_W  = $clog2(BEATS+1);
   localparam int OUT_SYMS = (SYM_NUM < PAR_LEN) ? SYM_NUM : PAR_LEN;

   state_t                                state;
   logic [PAR_LEN-1:0][EGF_ORDER-1:0]     parity;
   logic [PAR_LEN-1:0][EGF_ORDER-1:0]     parShifted;
   logic [SYM_NUM:0][PAR_LEN-1:0][EGF_ORDER-1:0] chain;
   logic [DRAIN_W-1:0]                    drainCnt;
   logic [CNT_W-1:0]                      symCnt;
   logic                                  inFire;
   logic                                  outFire;
   logic                                  lastBeat;

   assign symCnt   = (in_cnt > CNT_W'(SYM_NUM)) ? CNT_W'(SYM_NUM) : in_cnt;
   assign in_ready = (state != DRAIN);
   assign out_valid = (state == DRAIN);
   assign busy     = (state != IDLE);
   assign lastBeat = (drainCnt == DRAIN_W'(BEATS-1));
   assign out_last = out_valid && lastBeat;
   assign inFire   = in_valid && in_ready;
   assign outFire  = out_valid && out_ready;

   assign chain[0] = parity;

   // Stage k consumes the k-th symbol in time order, which sits at the top of the beat.
   for (genvar k = 0; k < SYM_NUM; k++) begin : g_step
      enc_lfsr_step #(
         .EGF_ORDER (EGF_ORDER),
         .PAR_LEN   (PAR_LEN)
      ) u_step (
         .parPrev (chain[k]),
         .sym     (in_data[SYM_NUM-1-k]),
         .enable  (CNT_W'(k) < symCnt),
         .parNext (chain[k+1])
      );
   end

   // Drain shifts toward the high index so the next beat always reads from the top.
   always_comb begin
      parShifted = '0;
      for (int j = SYM_NUM; j < PAR_LEN; j++) begin
         parShifted[j] = parity[j-SYM_NUM];
      end
   end

   always_comb begin
      out_data = '0;
      if (state == DRAIN) begin
         for (int i = 0; i < OUT_SYMS; i++) begin
            out_data[SYM_NUM-1-i] = parity[PAR_LEN-1-i];
         end
      end
   end

   // Parity is cleared on every return to IDLE so the next codeword starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         parity   <= '0;
         drainCnt <= '0;
      end else begin
         case (state)
            IDLE, ABSORB: begin
               if (inFire) begin
                  parity <= chain[SYM_NUM];
                  state  <= in_last ? DRAIN : ABSORB;
               end
            end
            DRAIN: begin
               if (outFire) begin
                  if (lastBeat) begin
                     state    <= IDLE;
                     parity   <= '0;
                     drainCnt <= '0;
                  end else begin
                     parity   <= parShifted;
                     drainCnt <= drainCnt + DRAIN_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               parity   <= '0;
               drainCnt <= '0;
            end
         endcase
      end
   end

endmodule
